// File: rtl/pocket.sv
// Shared bridge-bus types used by the bridge leaf, the host bridge master and the
// internal bridge arbiter.
package pocket;

    localparam int BRIDGE_W = 32;

    typedef logic [BRIDGE_W-1:0] bridge_addr_t;
    typedef logic [BRIDGE_W-1:0] bridge_data_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_DONE
    } bridge_arb_state_t;

    // Index width for an N-way selector; a 1-way selector still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bridge_rr_picker.sv
// Combinational round-robin picker: grants the first set request at or after the
// pointer, wrapping around, as a one-hot vector plus its binary index.
module bridge_rr_picker
    import pocket::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] pointer,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] index
);

    logic found;
    int   cand;

    always_comb begin
        gnt   = '0;
        index = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < N; i++) begin
            cand = int'(pointer) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                index     = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/bridge_arbiter.sv
// Shares one downstream bridge bus between NUM_REQ requesters: round-robin grant,
// one single-beat transaction at a time, fixed read latency, per-requester response.
module bridge_arbiter
    import pocket::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int RD_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_wr,
    input  logic [NUM_REQ*BRIDGE_W-1:0]  req_addr,
    input  logic [NUM_REQ*BRIDGE_W-1:0]  req_wr_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output bridge_data_t                 rsp_rd_data,
    output bridge_addr_t                 bus_addr,
    output bridge_data_t                 bus_wr_data,
    output logic                         bus_wr,
    output logic                         bus_rd,
    input  bridge_data_t                 bus_rd_data,
    output logic                         busy
);

    localparam int IDX_W = idx_width(NUM_REQ);

    if (RD_LATENCY < 1 || RD_LATENCY > 15) begin : g_bad_latency
        $error("bridge_arbiter: RD_LATENCY must be in 1..15");
    end
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("bridge_arbiter: NUM_REQ must be in 2..8");
    end

    bridge_arb_state_t   state;
    bridge_arb_state_t   state_nxt;
    logic [IDX_W-1:0]    pointer;
    logic [IDX_W-1:0]    gidx;
    logic                wr_q;
    logic [3:0]          lat_cnt;
    logic [NUM_REQ-1:0]  pick_gnt;
    logic [IDX_W-1:0]    pick_idx;
    logic                accept;

    // The requester just served drops to lowest priority on the next arbitration.
    function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] g);
        if (int'(g) == NUM_REQ - 1) begin
            return '0;
        end
        return g + 1'b1;
    endfunction

    bridge_rr_picker #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req     (req_valid),
        .pointer (pointer),
        .gnt     (pick_gnt),
        .index   (pick_idx)
    );

    assign accept = (state == ARB_IDLE) && (|req_valid);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        bus_wr    = 1'b0;
        bus_rd    = 1'b0;
        busy      = (state != ARB_IDLE);
        unique case (state)
            ARB_IDLE: begin
                if (accept) begin
                    req_ready = pick_gnt;
                    state_nxt = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                bus_wr    = wr_q;
                bus_rd    = !wr_q;
                state_nxt = wr_q ? ARB_DONE : ARB_WAIT;
            end
            ARB_WAIT: begin
                if (lat_cnt == 4'd0) begin
                    state_nxt = ARB_DONE;
                end
            end
            ARB_DONE: begin
                rsp_valid = NUM_REQ'(1) << gidx;
                state_nxt = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // Request fields are sampled only in the accept cycle; bus_addr/bus_wr_data then
    // hold until the next accept, including through IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pointer     <= '0;
            gidx        <= '0;
            wr_q        <= 1'b0;
            lat_cnt     <= '0;
            bus_addr    <= '0;
            bus_wr_data <= '0;
            rsp_rd_data <= '1;
        end else begin
            if (accept) begin
                gidx        <= pick_idx;
                wr_q        <= req_wr[pick_idx];
                bus_addr    <= req_addr[int'(pick_idx)*BRIDGE_W +: BRIDGE_W];
                bus_wr_data <= req_wr_data[int'(pick_idx)*BRIDGE_W +: BRIDGE_W];
            end
            if (state == ARB_ISSUE) begin
                lat_cnt <= 4'(RD_LATENCY - 1);
            end
            if (state == ARB_WAIT) begin
                if (lat_cnt == 4'd0) begin
                    rsp_rd_data <= bus_rd_data;
                end else begin
                    lat_cnt <= lat_cnt - 1'b1;
                end
            end
            if (state == ARB_DONE) begin
                pointer <= ptr_after(gidx);
            end
        end
    end

endmodule

// File: tb/tb_bridge_arbiter.sv
// Directed bench for bridge_arbiter (NUM_REQ=4, RD_LATENCY=3) with hand-computed
// expected grants, strobes, timings and response data.
module tb_bridge_arbiter;

    localparam int N   = 4;
    localparam int LAT = 3;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_wr;
    logic [N*32-1:0]   req_addr;
    logic [N*32-1:0]   req_wr_data;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      rsp_valid;
    logic [31:0]       rsp_rd_data;
    logic [31:0]       bus_addr;
    logic [31:0]       bus_wr_data;
    logic              bus_wr;
    logic              bus_rd;
    logic [31:0]       bus_rd_data;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int wr_cyc[6];

    bridge_arbiter #(
        .NUM_REQ    (N),
        .RD_LATENCY (LAT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_wr      (req_wr),
        .req_addr    (req_addr),
        .req_wr_data (req_wr_data),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_rd_data (rsp_rd_data),
        .bus_addr    (bus_addr),
        .bus_wr_data (bus_wr_data),
        .bus_wr      (bus_wr),
        .bus_rd      (bus_rd),
        .bus_rd_data (bus_rd_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs are driven at posedge+2; outputs are sampled at posedge+3.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d);
        req_valid[i]             = 1'b1;
        req_wr[i]                = wr;
        req_addr[i*32 +: 32]     = a;
        req_wr_data[i*32 +: 32]  = d;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"},  32'(req_ready),  32'h0);
        chk({tag, "_rspv"},   32'(rsp_valid),  32'h0);
        chk({tag, "_bus_wr"}, 32'(bus_wr),     32'h0);
        chk({tag, "_bus_rd"}, 32'(bus_rd),     32'h0);
        chk({tag, "_addr"},   bus_addr,        32'h0);
        chk({tag, "_wdata"},  bus_wr_data,     32'h0);
        chk({tag, "_rdata"},  rsp_rd_data,     32'hFFFF_FFFF);
        chk({tag, "_busy"},   32'(busy),       32'h0);
    endtask

    initial begin
        int exp4[3];
        int g;
        exp4 = '{3, 0, 1};

        reset_n     = 1'b0;
        req_valid   = '0;
        req_wr      = '0;
        req_addr    = '0;
        req_wr_data = '0;
        bus_rd_data = 32'hFFFF_0000;
        repeat (2) step();
        settle();
        chk_reset_outputs("rst");
        reset_n = 1'b1;
        step();

        // Single write from req0: ready at T, bus_wr at T+1, rsp at T+2.
        drive(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        settle();
        chk("t1_ready", 32'(req_ready), 32'h1);
        step();
        req_valid[0] = 1'b0;
        settle();
        chk("t1_bus_wr", 32'(bus_wr), 32'h1);
        chk("t1_bus_rd", 32'(bus_rd), 32'h0);
        chk("t1_addr", bus_addr, 32'h0000_0010);
        chk("t1_wdata", bus_wr_data, 32'hDEAD_BEEF);
        chk("t1_busy", 32'(busy), 32'h1);
        step();
        settle();
        chk("t1_rspv", 32'(rsp_valid), 32'h1);
        chk("t1_bus_wr_low", 32'(bus_wr), 32'h0);
        chk("t1_rdata_kept", rsp_rd_data, 32'hFFFF_FFFF);
        step();
        settle();
        chk("t1_idle_busy", 32'(busy), 32'h0);
        chk("t1_addr_hold", bus_addr, 32'h0000_0010);

        // Single read from req1 with latency 3: data on the bus in T+4, rsp at T+5.
        drive(1, 1'b0, 32'h0000_0020, 32'h0);
        settle();
        chk("t2_ready", 32'(req_ready), 32'h2);
        step();
        req_valid[1] = 1'b0;
        settle();
        chk("t2_bus_rd", 32'(bus_rd), 32'h1);
        chk("t2_bus_wr", 32'(bus_wr), 32'h0);
        chk("t2_addr", bus_addr, 32'h0000_0020);
        step();
        settle();
        chk("t2_wait_rd_low", 32'(bus_rd), 32'h0);
        step();
        step();
        bus_rd_data = 32'h1234_5678;
        settle();
        chk("t2_no_early_rsp", 32'(rsp_valid), 32'h0);
        step();
        bus_rd_data = 32'hFFFF_0000;
        settle();
        chk("t2_rspv", 32'(rsp_valid), 32'h2);
        chk("t2_rdata", rsp_rd_data, 32'h1234_5678);
        step();

        // Pointer now 2; requests 0,1,3 held -> grants 3, 0, 1.
        drive(0, 1'b1, 32'h0000_0100, 32'hA000_0000);
        drive(1, 1'b1, 32'h0000_0101, 32'hA000_0001);
        drive(3, 1'b1, 32'h0000_0103, 32'hA000_0003);
        for (int k = 0; k < 3; k++) begin
            g = exp4[k];
            settle();
            chk("t4_ready", 32'(req_ready), 32'(1 << g));
            step();
            req_valid[g] = 1'b0;
            settle();
            chk("t4_addr", bus_addr, 32'h0000_0100 + 32'(g));
            step();
            settle();
            chk("t4_rspv", 32'(rsp_valid), 32'(1 << g));
            step();
        end

        // Pointer 2 again; req0 and req1 held continuously for 6 writes.
        drive(0, 1'b1, 32'h0000_0200, 32'hB000_0000);
        drive(1, 1'b1, 32'h0000_0201, 32'hB000_0001);
        for (int k = 0; k < 6; k++) begin
            g = k % 2;
            settle();
            chk("t3_ready", 32'(req_ready), 32'(1 << g));
            step();
            settle();
            chk("t3_bus_wr", 32'(bus_wr), 32'h1);
            chk("t3_addr", bus_addr, 32'h0000_0200 + 32'(g));
            wr_cyc[k] = cyc;
            if (k > 0) begin
                chk("t3_gap", 32'(wr_cyc[k] - wr_cyc[k-1]), 32'd3);
            end
            step();
            if (k == 5) begin
                req_valid = '0;
            end
            settle();
            chk("t3_done_ready", 32'(req_ready), 32'h0);
            step();
        end

        // req0 pulsed only while busy with a req1 write: never granted.
        drive(1, 1'b1, 32'h0000_0300, 32'h0000_0055);
        settle();
        chk("t6_ready", 32'(req_ready), 32'h2);
        step();
        req_valid[1] = 1'b0;
        drive(0, 1'b1, 32'h0000_0400, 32'h0000_0066);
        settle();
        chk("t6_bus_wr", 32'(bus_wr), 32'h1);
        chk("t6_addr", bus_addr, 32'h0000_0300);
        step();
        req_valid[0] = 1'b0;
        settle();
        chk("t6_rspv", 32'(rsp_valid), 32'h2);
        step();
        settle();
        chk("t6_rdata_kept", rsp_rd_data, 32'h1234_5678);
        chk("t6_idle_ready", 32'(req_ready), 32'h0);
        chk("t6_idle_busy", 32'(busy), 32'h0);
        step();
        settle();
        chk("t6_no_bus_wr", 32'(bus_wr), 32'h0);
        chk("t6_no_bus_rd", 32'(bus_rd), 32'h0);
        chk("t6_addr_hold", bus_addr, 32'h0000_0300);
        chk("t6_still_idle", 32'(busy), 32'h0);

        // Reset asserted during WAIT of a req2 read aborts it.
        drive(2, 1'b0, 32'h0000_0500, 32'h0);
        settle();
        chk("t5_ready", 32'(req_ready), 32'h4);
        step();
        req_valid[2] = 1'b0;
        settle();
        chk("t5_bus_rd", 32'(bus_rd), 32'h1);
        step();
        settle();
        chk("t5_wait_busy", 32'(busy), 32'h1);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("t5_abort");
        step();
        settle();
        chk("t5_rspv_a", 32'(rsp_valid), 32'h0);
        step();
        step();
        settle();
        chk("t5_rspv_b", 32'(rsp_valid), 32'h0);
        reset_n = 1'b1;
        step();
        drive(1, 1'b1, 32'h0000_0600, 32'h0000_0077);
        drive(3, 1'b1, 32'h0000_0603, 32'h0000_0078);
        settle();
        chk("t5_ptr0_ready", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        settle();
        chk("t5_addr", bus_addr, 32'h0000_0600);
        step();
        settle();
        chk("t5_rspv", 32'(rsp_valid), 32'h2);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
